multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS-subset datapath (PC, IM, Reg_File, ALU, sign-extend, muxes).

---
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset datapath.
// Steps each instruction through FETCH/DECODE/EXEC/WB (or BR), waits on a
// variable-latency instruction memory, counts retired instructions and
// raises a sticky fault when a fetch never completes.
module multicycle_ctrl #(
    parameter int FETCH_TIMEOUT = 15,
    parameter int CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             imem_ready_i,
    input  logic [5:0]       instr_op_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    output logic             imem_req_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic             alu_src_o,
    output logic [2:0]       alu_op_o,
    output logic             shift_o,
    output logic             se_o,
    output logic             illegal_o,
    output logic             fault_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_BR     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_R     = 3'd1,
        C_SHIFT = 3'd2,
        C_ADDI  = 3'd3,
        C_SLTI  = 3'd4,
        C_BEQ   = 3'd5,
        C_ILL   = 3'd6
    } iclass_t;

    localparam logic [7:0] TIMEOUT = FETCH_TIMEOUT[7:0];

    state_t           state_q;
    iclass_t          class_q;
    iclass_t          class_d;
    logic [7:0]       wait_q;
    logic [CNT_W-1:0] retired_q;

    // Classify the instruction currently presented by the IR.
    always_comb begin
        class_d = C_ILL;
        unique case (instr_op_i)
            6'b000000: class_d = (funct_i == 6'b000000 || funct_i == 6'b000010) ? C_SHIFT : C_R;
            6'b001000: class_d = C_ADDI;
            6'b001010: class_d = C_SLTI;
            6'b000100: class_d = C_BEQ;
            default:   class_d = C_ILL;
        endcase
    end

    // Sequencer: state, latched class, fetch wait counter and retire count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            class_q   <= C_NONE;
            wait_q    <= 8'd0;
            retired_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (run_i) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready_i) begin
                        state_q <= S_DECODE;
                        wait_q  <= 8'd0;
                    end else if (wait_q == TIMEOUT) begin
                        state_q <= S_HALT;
                        wait_q  <= 8'd0;
                    end else begin
                        wait_q  <= wait_q + 8'd1;
                    end
                end
                S_DECODE: begin
                    class_q <= class_d;
                    if (class_d == C_ILL)      state_q <= run_i ? S_FETCH : S_IDLE;
                    else if (class_d == C_BEQ) state_q <= S_BR;
                    else                       state_q <= S_EXEC;
                end
                S_EXEC: state_q <= S_WB;
                S_WB, S_BR: begin
                    retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_q   <= run_i ? S_FETCH : S_IDLE;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Datapath controls decode straight from state/class; the fetch strobe and
    // branch PC write follow ready/zero within the same cycle, so they cannot
    // be registered without costing a cycle of latency.
    always_comb begin
        imem_req_o  = 1'b0;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = 1'b0;
        reg_write_o = 1'b0;
        reg_dst_o   = 1'b0;
        alu_src_o   = 1'b0;
        alu_op_o    = 3'b000;
        shift_o     = 1'b0;
        se_o        = 1'b0;
        illegal_o   = 1'b0;
        fault_o     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req_o = 1'b1;
                ir_write_o = imem_ready_i;
                pc_write_o = imem_ready_i;
            end
            S_DECODE: illegal_o = (class_d == C_ILL);
            S_EXEC, S_WB: begin
                reg_write_o = (state_q == S_WB);
                unique case (class_q)
                    C_R:     begin reg_dst_o = 1'b1; alu_op_o = 3'b010; end
                    C_SHIFT: begin reg_dst_o = 1'b1; alu_op_o = 3'b010; shift_o = 1'b1; end
                    C_ADDI:  begin alu_src_o = 1'b1; se_o = 1'b1; alu_op_o = 3'b000; end
                    C_SLTI:  begin alu_src_o = 1'b1; se_o = 1'b1; alu_op_o = 3'b011; end
                    default: ;
                endcase
            end
            S_BR: begin
                alu_op_o   = 3'b001;
                se_o       = 1'b1;
                pc_src_o   = 1'b1;
                pc_write_o = zero_i;
            end
            S_HALT:  fault_o = 1'b1;
            default: ;
        endcase
    end

    assign state_o   = state_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs change and outputs are sampled
// on the falling edge, so each check sees the state after the last rising edge.
module tb_multicycle_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        run_i;
    logic        imem_ready_i;
    logic [5:0]  instr_op_i;
    logic [5:0]  funct_i;
    logic        zero_i;
    logic        imem_req_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o;
    logic        reg_dst_o, alu_src_o, shift_o, se_o, illegal_o, fault_o;
    logic [2:0]  alu_op_o;
    logic [2:0]  state_o;
    logic [15:0] retired_o;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.FETCH_TIMEOUT(15), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .imem_ready_i(imem_ready_i),
        .instr_op_i(instr_op_i), .funct_i(funct_i), .zero_i(zero_i),
        .imem_req_o(imem_req_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
        .pc_src_o(pc_src_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
        .alu_src_o(alu_src_o), .alu_op_o(alu_op_o), .shift_o(shift_o), .se_o(se_o),
        .illegal_o(illegal_o), .fault_o(fault_o), .state_o(state_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    logic [13:0] outs;
    assign outs = {imem_req_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o, reg_dst_o,
                   alu_src_o, alu_op_o, shift_o, se_o, illegal_o, fault_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
        instr_op_i = op;
        funct_i    = fn;
    endtask

    initial begin
        rst_i = 1'b1; run_i = 1'b0; imem_ready_i = 1'b1; zero_i = 1'b0;
        set_ir(6'b000000, 6'b100000);
        #2;
        chk("rst_state", state_o, 0);
        chk("rst_outs", outs, 0);
        cyc();
        chk("rst_retired", retired_o, 0);

        // R-type add stream: 1,2,3,4 repeating
        rst_i = 1'b0; run_i = 1'b1;
        chk("idle", state_o, 0);
        cyc();
        chk("f_state", state_o, 1);
        chk("f_req", imem_req_o, 1);
        chk("f_irw", ir_write_o, 1);
        chk("f_pcw", pc_write_o, 1);
        chk("f_pcsrc", pc_src_o, 0);
        cyc();
        chk("d_state", state_o, 2);
        chk("d_ill", illegal_o, 0);
        chk("d_irw", ir_write_o, 0);
        cyc();
        chk("e_state", state_o, 3);
        chk("e_r_ctl", {reg_dst_o, alu_src_o, alu_op_o, shift_o, reg_write_o}, 7'b1_0_010_0_0);
        cyc();
        chk("wb_state", state_o, 4);
        chk("wb_regw", reg_write_o, 1);
        chk("wb_pcw", pc_write_o, 0);
        chk("wb_hold", {reg_dst_o, alu_op_o}, 4'b1_010);
        chk("wb_ret", retired_o, 0);
        cyc();
        chk("r_ret1", retired_o, 1);
        for (int i = 0; i < 2; i++) begin
            cyc(); chk("r_s2", state_o, 2);
            cyc(); chk("r_s3", state_o, 3);
            cyc(); chk("r_s4", state_o, 4);
            cyc(); chk("r_s1", state_o, 1);
            chk("r_ret", retired_o, 2 + i);
        end

        // sll -> shift class
        set_ir(6'b000000, 6'b000000);
        cyc(); cyc();
        chk("sll_ctl", {reg_dst_o, alu_src_o, alu_op_o, shift_o, se_o}, 7'b1_0_010_1_0);
        cyc();
        chk("sll_wb", {reg_write_o, shift_o}, 2'b11);
        cyc();
        chk("sll_ret", retired_o, 4);

        // addi
        set_ir(6'b001000, 6'b000000);
        cyc(); cyc();
        chk("addi_ctl", {reg_dst_o, alu_src_o, alu_op_o, shift_o, se_o}, 7'b0_1_000_0_1);
        cyc();
        chk("addi_wb", reg_write_o, 1);
        cyc();
        chk("addi_ret", retired_o, 5);

        // slti
        set_ir(6'b001010, 6'b000000);
        cyc(); cyc();
        chk("slti_ctl", {reg_dst_o, alu_src_o, alu_op_o, shift_o, se_o}, 7'b0_1_011_0_1);
        cyc(); cyc();
        chk("slti_ret", retired_o, 6);

        // beq taken then not taken, 3 cycles each
        set_ir(6'b000100, 6'b000000); zero_i = 1'b1;
        cyc(); chk("beq_d", state_o, 2);
        cyc();
        chk("br_state", state_o, 5);
        chk("br_taken", {pc_write_o, pc_src_o, alu_op_o, alu_src_o, se_o, reg_write_o}, 8'b1_1_001_0_1_0);
        cyc();
        chk("br_next", state_o, 1);
        chk("br_ret", retired_o, 7);
        zero_i = 1'b0;
        cyc(); cyc();
        chk("br_nt", {pc_write_o, pc_src_o}, 2'b01);
        cyc();
        chk("br_nt_ret", retired_o, 8);

        // illegal opcode
        set_ir(6'b111111, 6'b000000);
        cyc();
        chk("ill_pulse", illegal_o, 1);
        cyc();
        chk("ill_state", state_o, 1);
        chk("ill_clr", illegal_o, 0);
        chk("ill_ret", retired_o, 8);

        // run dropped in EXEC: WB completes then IDLE
        set_ir(6'b000000, 6'b100000);
        cyc(); cyc();
        chk("drop_e", state_o, 3);
        run_i = 1'b0;
        cyc();
        chk("drop_wb", reg_write_o, 1);
        cyc();
        chk("drop_idle", state_o, 0);
        chk("drop_outs", outs, 0);
        chk("drop_ret", retired_o, 9);
        cyc();
        chk("drop_stay", state_o, 0);

        // async reset mid-WB
        run_i = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        chk("pre_rst_wb", state_o, 4);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_state", state_o, 0);
        chk("arst_outs", outs, 0);
        chk("arst_ret", retired_o, 0);

        // fetch timeout: 16 FETCH cycles with ready low -> HALT
        imem_ready_i = 1'b0;
        cyc(); rst_i = 1'b0;
        cyc();
        chk("to_f1", {state_o, imem_req_o, ir_write_o}, 5'b001_1_0);
        repeat (15) cyc();
        chk("to_f16", state_o, 1);
        cyc();
        chk("to_halt", state_o, 6);
        chk("to_fault", outs, 14'b1);
        run_i = 1'b0; imem_ready_i = 1'b1;
        cyc(); cyc();
        chk("halt_stay", {state_o, fault_o}, 4'b110_1);
        run_i = 1'b1;
        cyc();
        chk("halt_run", state_o, 6);

        // ready arriving on the 16th FETCH cycle wins
        rst_i = 1'b1; imem_ready_i = 1'b0;
        cyc(); rst_i = 1'b0;
        chk("rst_fault", fault_o, 0);
        cyc();
        repeat (15) cyc();
        imem_ready_i = 1'b1;
        #1;
        chk("late_irw", ir_write_o, 1);
        cyc();
        chk("late_dec", state_o, 2);
        chk("late_nofault", fault_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Structural rules that must hold every cycle.
    always @(negedge clk_i) begin
        if (!rst_i && reg_write_o && pc_write_o) begin
            total++; bad++;
            $display("FAIL excl regw=%0b pcw=%0b required not both 1", reg_write_o, pc_write_o);
        end
        if (!rst_i && ir_write_o && state_o != 3'd1) begin
            total++; bad++;
            $display("FAIL irw_state state=%0d required 1", state_o);
        end
    end

endmodule
